// File: rtl/layer_compositor.sv
// layer_compositor: raster scan generator plus N-layer priority compositor with cursor overlay.
// Optional cursor blink driven by a frame counter, enabled by defining COMPOSITOR_BLINK_EN.
module layer_compositor #(
    parameter int WIDTH        = 640,
    parameter int HEIGHT       = 480,
    parameter int NUM_LAYERS   = 4,
    parameter int COLOR_WIDTH  = 3,
    parameter int READ_LATENCY = 1,
    parameter int TRANSPARENT  = 0,
    parameter int BLINK_LOG2   = 5
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              advance,
    input  logic [COLOR_WIDTH-1:0]            background_color,
    input  logic [COLOR_WIDTH-1:0]            cursor_color,
    input  logic                              cursor_visible,
    input  logic [NUM_LAYERS*COLOR_WIDTH-1:0] layer_colors,
    input  logic [NUM_LAYERS-1:0]             layer_visible,
    output logic [$clog2(WIDTH)-1:0]          request_x,
    output logic [$clog2(HEIGHT)-1:0]         request_y,
    output logic [$clog2(WIDTH)-1:0]          render_x,
    output logic [$clog2(HEIGHT)-1:0]         render_y,
    output logic [COLOR_WIDTH-1:0]            render_color,
    output logic                              render_valid,
    output logic                              frame_done
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam logic [XW-1:0]          X_LAST     = XW'(WIDTH - 1);
    localparam logic [YW-1:0]          Y_LAST     = YW'(HEIGHT - 1);
    localparam logic [COLOR_WIDTH-1:0] CLEAR      = COLOR_WIDTH'(TRANSPARENT);
    localparam logic [BLINK_LOG2-1:0]  BLINK_HALF = BLINK_LOG2'(1 << (BLINK_LOG2 - 1));

    logic [XW-1:0] pipe_x [READ_LATENCY];
    logic [YW-1:0] pipe_y [READ_LATENCY];
    logic          pipe_v [READ_LATENCY];

    logic [XW-1:0]          tail_x;
    logic [YW-1:0]          tail_y;
    logic                   tail_v;
    logic                   tail_last;
    logic                   blink_hide;
    logic                   cursor_on;
    logic [COLOR_WIDTH-1:0] comp_color;
    logic [BLINK_LOG2-1:0]  blink_count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            request_x <= '0;
            request_y <= '0;
        end else if (advance) begin
            if (request_x == X_LAST) begin
                request_x <= '0;
                request_y <= (request_y == Y_LAST) ? '0 : request_y + 1'b1;
            end else begin
                request_x <= request_x + 1'b1;
            end
        end
    end

    // NOTE: the alignment pipeline is a handful of flops, so it is fully reset to keep valid bits clean.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_x[i] <= '0;
                pipe_y[i] <= '0;
                pipe_v[i] <= 1'b0;
            end
        end else if (advance) begin
            pipe_x[0] <= request_x;
            pipe_y[0] <= request_y;
            pipe_v[0] <= 1'b1;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_x[i] <= pipe_x[i-1];
                pipe_y[i] <= pipe_y[i-1];
                pipe_v[i] <= pipe_v[i-1];
            end
        end
    end

    assign tail_x    = pipe_x[READ_LATENCY-1];
    assign tail_y    = pipe_y[READ_LATENCY-1];
    assign tail_v    = pipe_v[READ_LATENCY-1];
    assign tail_last = tail_v && (tail_x == X_LAST) && (tail_y == Y_LAST);

`ifdef COMPOSITOR_BLINK_EN
    // Counts emitted frames; the increment lands on the same edge as the frame's last pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_count <= '0;
        end else if (advance && tail_last) begin
            blink_count <= blink_count + 1'b1;
        end
    end
`else
    assign blink_count = '0;
`endif

    assign blink_hide = (blink_count >= BLINK_HALF);
    assign cursor_on  = cursor_visible && !blink_hide;

    // NOTE: comp_color gets its default before any condition so no latch is inferred.
    always_comb begin
        comp_color = background_color;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (layer_visible[i] && (layer_colors[i*COLOR_WIDTH +: COLOR_WIDTH] != CLEAR)) begin
                comp_color = layer_colors[i*COLOR_WIDTH +: COLOR_WIDTH];
            end
        end
        if (cursor_on && (cursor_color != CLEAR)) begin
            comp_color = cursor_color;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            render_x     <= '0;
            render_y     <= '0;
            render_color <= '0;
            render_valid <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= advance && tail_last;
            if (advance) begin
                render_valid <= tail_v;
                if (tail_v) begin
                    render_x     <= tail_x;
                    render_y     <= tail_y;
                    render_color <= comp_color;
                end
            end
        end
    end

endmodule

// File: tb/tb_layer_compositor.sv
// Self-checking bench for layer_compositor: directed scenarios plus randomized compositing,
// checked against a pixel-count based reference model.
module tb_layer_compositor;

    localparam int W     = 4;
    localparam int H     = 3;
    localparam int NL    = 3;
    localparam int CW    = 3;
    localparam int L     = 2;
    localparam int BL    = 2;
    localparam int FRAME = W * H;

    logic          clk;
    logic          reset;
    logic          advance;
    logic [CW-1:0] background_color;
    logic [CW-1:0] cursor_color;
    logic          cursor_visible;
    logic [NL*CW-1:0] layer_colors;
    logic [NL-1:0] layer_visible;
    logic [1:0]    request_x;
    logic [1:0]    request_y;
    logic [1:0]    render_x;
    logic [1:0]    render_y;
    logic [CW-1:0] render_color;
    logic          render_valid;
    logic          frame_done;

    logic [CW-1:0] lc [NL];

    int            n_checks;
    int            n_errors;
    int            adv_n;
    logic [CW-1:0] exp_color;
    logic          exp_fd;

    layer_compositor #(
        .WIDTH(W), .HEIGHT(H), .NUM_LAYERS(NL), .COLOR_WIDTH(CW),
        .READ_LATENCY(L), .TRANSPARENT(0), .BLINK_LOG2(BL)
    ) dut (
        .clk(clk), .reset(reset), .advance(advance),
        .background_color(background_color), .cursor_color(cursor_color),
        .cursor_visible(cursor_visible), .layer_colors(layer_colors),
        .layer_visible(layer_visible), .request_x(request_x), .request_y(request_y),
        .render_x(render_x), .render_y(render_y), .render_color(render_color),
        .render_valid(render_valid), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always_comb begin
        layer_colors = '0;
        for (int i = 0; i < NL; i++) layer_colors[i*CW +: CW] = lc[i];
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    // Colour of rendered pixel number p (counted since reset), from the current inputs.
    function automatic logic [CW-1:0] ref_color(input int p);
        logic show_cursor;
        show_cursor = cursor_visible && (cursor_color != 0);
`ifdef COMPOSITOR_BLINK_EN
        if (((p / FRAME) % (1 << BL)) >= (1 << (BL - 1))) show_cursor = 1'b0;
`endif
        if (show_cursor) return cursor_color;
        for (int i = NL - 1; i >= 0; i--) begin
            if (layer_visible[i] && (lc[i] != 0)) return lc[i];
        end
        return background_color;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ph);
        logic v;
        int   p;
        v = (adv_n >= L + 1);
        p = adv_n - (L + 1);
        check({ph, ".request_x"}, request_x, adv_n % W);
        check({ph, ".request_y"}, request_y, (adv_n / W) % H);
        check({ph, ".render_valid"}, render_valid, v);
        check({ph, ".render_x"}, render_x, v ? p % W : 0);
        check({ph, ".render_y"}, render_y, v ? (p / W) % H : 0);
        check({ph, ".render_color"}, render_color, exp_color);
        check({ph, ".frame_done"}, frame_done, exp_fd);
    endtask

    task automatic model_reset();
        adv_n     = 0;
        exp_color = '0;
        exp_fd    = 1'b0;
    endtask

    task automatic step(input string ph, input logic adv);
        advance = adv;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else if (adv) begin
            adv_n++;
            if (adv_n >= L + 1) exp_color = ref_color(adv_n - L - 1);
            exp_fd = (adv_n >= L + 1) && (((adv_n - L - 1) % FRAME) == FRAME - 1);
        end else begin
            exp_fd = 1'b0;
        end
        #1;
        check_all(ph);
    endtask

    function automatic int rendered_pos();
        return (adv_n >= L + 1) ? (adv_n - L - 1) % FRAME : -1;
    endfunction

    initial begin
        clk = 1'b0;
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        advance = 1'b0;
        background_color = 3'd5;
        cursor_color = 3'd0;
        cursor_visible = 1'b0;
        layer_visible = '0;
        for (int i = 0; i < NL; i++) lc[i] = '0;
        model_reset();
        #2;
        check_all("reset");
        step("reset_hold", 1'b0);
        step("reset_hold", 1'b1);
        reset = 1'b0;

        // Latency and scan over a full frame and past the wrap.
        for (int k = 0; k < L + 1 + FRAME + 3; k++) step("scan", 1'b1);

        // Directed priority cases.
        lc[0] = 3'd2; lc[1] = 3'd4; lc[2] = 3'd7;
        layer_visible = 3'b011; cursor_visible = 1'b1; cursor_color = 3'd0;
        step("prio_top_layer", 1'b1);
        layer_visible = 3'b001;
        step("prio_layer1_hidden", 1'b1);
        cursor_color = 3'd6;
        step("prio_cursor", 1'b1);
        cursor_color = 3'd0; lc[1] = 3'd0; layer_visible = 3'b011;
        step("prio_transparent_layer", 1'b1);
        layer_visible = 3'b000; background_color = 3'd0;
        step("prio_bg_transparent", 1'b1);
        layer_visible = 3'b110; lc[1] = 3'd3;
        step("prio_layer2_top", 1'b1);

        // Randomized inputs with random stalls.
        for (int k = 0; k < 80; k++) begin
            for (int i = 0; i < NL; i++) lc[i] = CW'($urandom_range(0, 7));
            layer_visible    = NL'($urandom_range(0, 7));
            cursor_color     = CW'($urandom_range(0, 7));
            cursor_visible   = 1'($urandom_range(0, 1));
            background_color = CW'($urandom_range(0, 7));
            step("random", ($urandom_range(0, 3) != 0));
        end

        // Stall mid-line while request sits at (2,1).
        for (int k = 0; k < 2 * FRAME && (adv_n % FRAME) != 6; k++) step("stall_seek", 1'b1);
        for (int k = 0; k < 5; k++) step("stall_hold", 1'b0);
        for (int k = 0; k < 4; k++) step("stall_resume", 1'b1);

        // Asynchronous reset between edges while pixel (1,2) is displayed.
        for (int k = 0; k < 2 * FRAME && rendered_pos() != 9; k++) step("areset_seek", 1'b1);
        reset = 1'b1;
        model_reset();
        #1;
        check_all("areset_async");
        step("areset_hold", 1'b1);
        step("areset_hold", 1'b1);
        reset = 1'b0;
        for (int k = 0; k < L + 4; k++) step("areset_refill", 1'b1);

        // Stall directly after the last pixel of a frame.
        for (int k = 0; k < 2 * FRAME && rendered_pos() != FRAME - 1; k++) step("wrap_seek", 1'b1);
        for (int k = 0; k < 3; k++) step("wrap_stall", 1'b0);
        for (int k = 0; k < 2; k++) step("wrap_resume", 1'b1);

        // Cursor over five frames from a fresh reset.
        cursor_color = 3'd3; cursor_visible = 1'b1;
        layer_visible = '0; background_color = 3'd5;
        reset = 1'b1;
        step("blink_reset", 1'b0);
        reset = 1'b0;
        for (int k = 0; k < 5 * FRAME + L + 1; k++) step("blink", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/layer_compositor.md
Name: layer_compositor

Overview:
- Parametrised N-layer raster compositor, the next generation of the fixed four-canvas compositor.
- Owns the raster scan. Drives request_x/request_y to the canvas layers and the cursor renderer. Merges their returned colour indices by priority with per-index transparency. Emits a coordinate-aligned pixel stream to color_index_to_rgb and VGA_framebuffer.
- Adds a stall input, a pipeline-valid flag, a frame-done pulse and configurable source read latency.

Parameters:
- WIDTH, 640, pixels per line.
- HEIGHT, 480, lines per frame.
- NUM_LAYERS, 4, number of canvas layers (>=1).
- COLOR_WIDTH, 3, bits per colour index.
- READ_LATENCY, 1, cycles from request_x/y to valid layer_colors and cursor_color (>=1).
- TRANSPARENT, 0, colour index treated as "no paint" on layers and cursor.
- BLINK_LOG2, 5, frame-counter width for the optional blink feature.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- advance  input  1  high: scan and pipeline step this cycle; low: everything holds.
- background_color  input  COLOR_WIDTH  colour used when nothing is painted.
- cursor_color  input  COLOR_WIDTH  cursor renderer output for the requested pixel.
- cursor_visible  input  1  cursor overlay enable.
- layer_colors  input  NUM_LAYERS*COLOR_WIDTH  layer i occupies [i*COLOR_WIDTH +: COLOR_WIDTH].
- layer_visible  input  NUM_LAYERS  per-layer enable.
- request_x  output  $clog2(WIDTH)  scan column presented to sources.
- request_y  output  $clog2(HEIGHT)  scan row presented to sources.
- render_x  output  $clog2(WIDTH)  column of render_color.
- render_y  output  $clog2(HEIGHT)  row of render_color.
- render_color  output  COLOR_WIDTH  composited colour index.
- render_valid  output  1  render_* hold a real pixel.
- frame_done  output  1  one-cycle pulse when the last pixel of a frame is emitted.

Behaviour:
Reset:
- request_x/y = 0; render_x/y/color = 0; render_valid = 0; frame_done = 0.
- Pipeline valid bits and blink counter cleared.
- Reset mid-frame aborts the frame; the scan restarts at (0,0).

Scan counter:
- Raster order, x fastest. Steps only on cycles with advance = 1.
- x = WIDTH-1 wraps to 0 and y increments.
- (WIDTH-1, HEIGHT-1) wraps to (0,0) with no gap cycle.

Pipeline:
- READ_LATENCY stages carry {x, y, valid} beside the source read, followed by one registered compose stage.
- Latency is READ_LATENCY+1 advancing cycles from request to render.
- advance = 0 freezes every stage and the scan counter. request_x/y do not change, so source outputs stay stable.
- render_valid rises after READ_LATENCY+1 advancing cycles following reset, then stays high.

Compose priority, evaluated on inputs aligned to the pipeline tail:
1. Cursor, when cursor_visible = 1 and cursor_color != TRANSPARENT.
2. Otherwise the highest-index layer i with layer_visible[i] = 1 and its colour != TRANSPARENT. Layer NUM_LAYERS-1 is on top.
3. Otherwise background_color.
- background_color is used even if it equals TRANSPARENT.

frame_done:
- Asserted in the cycle where render_x = WIDTH-1, render_y = HEIGHT-1 and render_valid = 1.
- Held for exactly one cycle, even if advance then drops.
- When the last pixel is emitted on an advancing cycle, that pixel's pulse and the next frame's first pixel are never in the same cycle.

Visibility timing:
- layer_visible and cursor_visible are sampled at the compose stage, not delayed.
- A change takes effect on the next rendered pixel.

Optional Feature:
Macro: COMPOSITOR_BLINK_EN.
- Defined:
  - Adds a BLINK_LOG2-bit frame counter, incremented on each frame_done and cleared by reset. It wraps naturally.
  - The cursor participates in priority only while the counter MSB = 0. When MSB = 1 the cursor is treated as transparent.
- Undefined:
  - No counter is built.
  - The cursor participates whenever cursor_visible = 1.

Test Plan:
- Latency and scan: WIDTH=4, HEIGHT=3, READ_LATENCY=2, advance held 1, all layers invisible, background=5 -> render_valid rises on the 3rd cycle after reset release. Pixels follow (0,0),(1,0)..(3,2) with colour 5. frame_done pulses only at (3,2); next cycle shows (0,0).
- Priority: layer0=2, layer1=4, both visible, cursor_color=0 -> render 4. Set layer_visible[1]=0 -> render 2. Set cursor_color=6 with cursor_visible=1 -> render 6. Set layer1=TRANSPARENT with layer_visible[1]=1 -> render 2.
- Stall: drop advance for 5 cycles mid-line at request (2,1) -> request_x/y, render_* and render_valid are all unchanged for 5 cycles. On resume the next pixel follows with no skip or duplicate.
- Async reset mid-frame: assert reset between clock edges at pixel (1,2) -> outputs are 0 before the next edge. After release the scan restarts at (0,0) and render_valid refills after READ_LATENCY+1 cycles.
- Wrap with stall on last pixel: advance = 0 on the cycle after (3,2) is rendered -> frame_done lasts exactly one cycle and does not re-pulse while stalled.
- Blink (COMPOSITOR_BLINK_EN, BLINK_LOG2=2, cursor_color=3 everywhere) -> frames 0-1 render 3; frames 2-3 render the layer/background colour; frame 4 renders 3 again. Without the macro, every frame renders 3.
